// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic {ST_IDLE, ST_BUSY} arb_state_e;
    typedef enum logic {GNT_IF, GNT_D} arb_grant_e;

    localparam int XLEN     = 32;
    localparam int LAT_W    = 3;
    localparam int STARVE_W = 4;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port fixed-latency memory between fetch and load/store ports.
// Optional performance counters are enabled with MEM_ARB_PERF_CNT_EN.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_rsp_valid,
    output logic [XLEN-1:0]   if_rsp_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [XLEN-1:0]   d_addr,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_rsp_valid,
    output logic [XLEN-1:0]   d_rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_d_stall,
    output logic [31:0]       perf_conflict
`endif
);

    arb_state_e          r_state, w_state_next;
    arb_grant_e          r_grant, w_grant_next;
    logic                r_d_we, w_d_we_next;
    logic [LAT_W-1:0]    r_lat_cnt, w_lat_next;
    logic [STARVE_W-1:0] r_starve_cnt, w_starve_next;

    logic w_starved;
    logic w_pick_d;
    logic w_pick_if;
    logic w_unused_addr;

    // Fetch overrides data only once it has lost STARVE_LIMIT grants in a row.
    assign w_starved = (r_starve_cnt == STARVE_W'(STARVE_LIMIT)) && if_req_valid;
    assign w_pick_d  = d_req_valid && !w_starved;
    assign w_pick_if = if_req_valid && !w_pick_d;

    assign w_unused_addr = ^{if_addr[XLEN-1:ADDR_W+2], if_addr[1:0],
                             d_addr[XLEN-1:ADDR_W+2], d_addr[1:0]};

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_d_we_next   = r_d_we;
        w_lat_next    = r_lat_cnt;
        w_starve_next = r_starve_cnt;
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        if_rsp_valid  = 1'b0;
        if_rsp_rdata  = '0;
        d_rsp_valid   = 1'b0;
        d_rsp_rdata   = '0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_wstrb     = '0;
        mem_addr      = '0;
        mem_wdata     = '0;
        unique case (r_state)
            ST_IDLE: begin
                // Reset also gates the combinational grant so outputs stay 0 during reset.
                if (!reset && w_pick_d) begin
                    d_req_ready   = 1'b1;
                    mem_en        = 1'b1;
                    mem_addr      = d_addr[ADDR_W+1:2];
                    mem_we        = d_we;
                    mem_wstrb     = d_we ? d_wstrb : 4'b0000;
                    mem_wdata     = d_we ? d_wdata : '0;
                    w_grant_next  = GNT_D;
                    w_d_we_next   = d_we;
                    w_lat_next    = LAT_W'(MEM_LATENCY);
                    w_state_next  = ST_BUSY;
                    if (if_req_valid) begin
                        if (r_starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                            w_starve_next = r_starve_cnt + STARVE_W'(1);
                        end
                    end else begin
                        w_starve_next = '0;
                    end
                end else if (!reset && w_pick_if) begin
                    if_req_ready  = 1'b1;
                    mem_en        = 1'b1;
                    mem_addr      = if_addr[ADDR_W+1:2];
                    w_grant_next  = GNT_IF;
                    w_d_we_next   = 1'b0;
                    w_lat_next    = LAT_W'(MEM_LATENCY);
                    w_starve_next = '0;
                    w_state_next  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_lat_next = r_lat_cnt - LAT_W'(1);
                if (r_lat_cnt == LAT_W'(1)) begin
                    w_state_next = ST_IDLE;
                    if (r_grant == GNT_D) begin
                        d_rsp_valid = 1'b1;
                        d_rsp_rdata = r_d_we ? '0 : mem_rdata;
                    end else begin
                        if_rsp_valid = 1'b1;
                        if_rsp_rdata = mem_rdata;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_IF;
            r_d_we       <= 1'b0;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_d_we       <= w_d_we_next;
            r_lat_cnt    <= w_lat_next;
            r_starve_cnt <= w_starve_next;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
            perf_conflict <= '0;
        end else begin
            if (if_req_valid && !if_req_ready) perf_if_stall <= perf_if_stall + 32'd1;
            if (d_req_valid && !d_req_ready)   perf_d_stall  <= perf_d_stall + 32'd1;
            if (r_state == ST_IDLE && if_req_valid && d_req_valid) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`else
    // Counters are compiled out; the arbiter core above is unchanged.
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter (MEM_LATENCY=2, STARVE_LIMIT=2).
module tb_unified_mem_arbiter;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0]       if_addr, if_rsp_rdata;
    logic              d_req_valid, d_req_ready, d_we, d_rsp_valid;
    logic [3:0]        d_wstrb;
    logic [31:0]       d_addr, d_wdata, d_rsp_rdata;
    logic              mem_en, mem_we;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]       perf_if_stall, perf_d_stall, perf_conflict;
`endif

    int total = 0;
    int bad   = 0;

    unified_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .MEM_LATENCY  (2),
        .STARVE_LIMIT (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_rdata (if_rsp_rdata),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_addr       (d_addr),
        .d_we         (d_we),
        .d_wstrb      (d_wstrb),
        .d_wdata      (d_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_rdata  (d_rsp_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_d_stall  (perf_d_stall),
        .perf_conflict (perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: read data appears two cycles after the mem_en cycle.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_p1 = '0;
    logic [31:0] rd_p2 = '0;
    assign mem_rdata = rd_p2;

    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_en) begin
            w = mem[mem_addr];
            rd_p1 <= w;
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                end
                mem[mem_addr] = w;
            end
        end
        rd_p2 <= rd_p1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] pat;
        int sb_conf, sb_ifs, sb_ds;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[2] = 32'hCAFE_0002;
        mem[4] = 32'h0050_0093;
        mem[5] = 32'h00A0_0113;
        mem[9] = 32'h1111_1111;

        reset = 1'b1;
        if_req_valid = 0; if_addr = '0;
        d_req_valid = 0; d_addr = '0; d_we = 0; d_wstrb = '0; d_wdata = '0;

        // Reset state
        settle;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_d_rsp", d_rsp_valid, 0);
        step;
        reset = 1'b0;

        // 1. Fetch only, back-to-back
        if_req_valid = 1; if_addr = 32'h10;
        settle;
        chk("t1_if_ready", if_req_ready, 1);
        chk("t1_d_ready", d_req_ready, 0);
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_addr", mem_addr, 4);
        chk("t1_mem_we", mem_we, 0);
        step;
        if_addr = 32'h14;
        settle;
        chk("t1_busy_ready", if_req_ready, 0);
        chk("t1_busy_mem_en", mem_en, 0);
        chk("t1_rsp_early", if_rsp_valid, 0);
        step;
        settle;
        chk("t1_rsp_valid", if_rsp_valid, 1);
        chk("t1_rsp_rdata", if_rsp_rdata, 32'h0050_0093);
        chk("t1_t2_ready", if_req_ready, 0);
        step;
        settle;
        chk("t1_next_grant", if_req_ready, 1);
        chk("t1_next_addr", mem_addr, 5);
        step;
        if_req_valid = 0;
        settle;
        chk("t1_rsp2_early", if_rsp_valid, 0);
        step;
        settle;
        chk("t1_rsp2_valid", if_rsp_valid, 1);
        chk("t1_rsp2_rdata", if_rsp_rdata, 32'h00A0_0113);
        step;

        // 2. Partial store then load back
        d_req_valid = 1; d_we = 1; d_addr = 32'h24; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        settle;
        chk("t2_st_ready", d_req_ready, 1);
        chk("t2_st_mem_we", mem_we, 1);
        chk("t2_st_wstrb", mem_wstrb, 4'b0011);
        chk("t2_st_addr", mem_addr, 9);
        chk("t2_st_wdata", mem_wdata, 32'hDEAD_BEEF);
        step;
        d_req_valid = 0; d_we = 0; d_wstrb = '0; d_wdata = '0;
        settle;
        step;
        settle;
        chk("t2_st_ack", d_rsp_valid, 1);
        chk("t2_st_ack_rdata", d_rsp_rdata, 0);
        chk("t2_st_if_rsp", if_rsp_valid, 0);
        step;
        d_req_valid = 1;
        settle;
        chk("t2_ld_ready", d_req_ready, 1);
        chk("t2_ld_mem_we", mem_we, 0);
        chk("t2_ld_wstrb", mem_wstrb, 0);
        step;
        d_req_valid = 0;
        settle;
        step;
        settle;
        chk("t2_ld_rsp", d_rsp_valid, 1);
        chk("t2_ld_rdata", d_rsp_rdata, 32'h1111_BEEF);
        step;

        // 5. Address wrap and ignored low bits
        d_req_valid = 1; d_addr = 32'hFFFF_F008;
        settle;
        chk("t5_wrap_addr", mem_addr, 2);
        step;
        d_req_valid = 0;
        settle;
        step;
        settle;
        chk("t5_wrap_rdata", d_rsp_rdata, 32'hCAFE_0002);
        step;
        d_req_valid = 1; d_addr = 32'h0000_000B;
        settle;
        chk("t5_low_addr", mem_addr, 2);
        step;
        d_req_valid = 0;
        settle;
        step;
        settle;
        chk("t5_low_rdata", d_rsp_rdata, 32'hCAFE_0002);
        step;

        // 4. Reset in the middle of a load
        d_req_valid = 1; d_addr = 32'h10;
        settle;
        chk("t4_ld_ready", d_req_ready, 1);
        step;
        d_req_valid = 0; reset = 1; if_req_valid = 1; if_addr = 32'h10;
        settle;
        chk("t4_rst_d_rsp", d_rsp_valid, 0);
        chk("t4_rst_mem_en", mem_en, 0);
        chk("t4_rst_if_ready", if_req_ready, 0);
        step;
        settle;
        chk("t4_rst_d_rsp2", d_rsp_valid, 0);
        chk("t4_rst_d_rdata", d_rsp_rdata, 0);
        step;
        reset = 0; if_req_valid = 0;
        d_req_valid = 1; d_addr = 32'h24;
        settle;
        chk("t4_post_ready", d_req_ready, 1);
        step;
        d_req_valid = 0;
        settle;
        step;
        settle;
        chk("t4_post_rsp", d_rsp_valid, 1);
        chk("t4_post_rdata", d_rsp_rdata, 32'h1111_BEEF);
        step;

        // 3 (and 6). Both ports valid continuously: D,D,IF,D,D,IF
        reset = 1;
        settle;
`ifdef MEM_ARB_PERF_CNT_EN
        chk("t6_rst_conflict", perf_conflict, 0);
        chk("t6_rst_if_stall", perf_if_stall, 0);
`endif
        step;
        reset = 0;
        if_req_valid = 1; if_addr = 32'h10;
        d_req_valid = 1; d_addr = 32'h24; d_we = 0;
        pat = 6'b011011;
        sb_conf = 0; sb_ifs = 0; sb_ds = 0;
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 3; c++) begin
                settle;
`ifdef MEM_ARB_PERF_CNT_EN
                if (i == 4 && c == 0) begin
                    chk("t6_conflict", perf_conflict, sb_conf);
                    chk("t6_if_stall", perf_if_stall, sb_ifs);
                    chk("t6_d_stall", perf_d_stall, sb_ds);
                end
`endif
                if (c == 0) begin
                    chk($sformatf("t3_d_grant%0d", i), d_req_ready, pat[i]);
                    chk($sformatf("t3_if_grant%0d", i), if_req_ready, !pat[i]);
                    sb_conf++;
                    if (pat[i]) sb_ifs++;
                    else sb_ds++;
                end else begin
                    chk($sformatf("t3_busy_rdy%0d_%0d", i, c), {d_req_ready, if_req_ready}, 0);
                    sb_ifs++;
                    sb_ds++;
                end
                if (c == 2) begin
                    chk($sformatf("t3_d_rsp%0d", i), d_rsp_valid, pat[i]);
                    chk($sformatf("t3_if_rsp%0d", i), if_rsp_valid, !pat[i]);
                    chk($sformatf("t3_rdata%0d", i), pat[i] ? d_rsp_rdata : if_rsp_rdata,
                        pat[i] ? 32'h1111_BEEF : 32'h0050_0093);
                end
                step;
            end
        end
        if_req_valid = 0; d_req_valid = 0;
        settle;
        chk("end_idle_mem_en", mem_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
